pdm_modulator: RTL and testbench
================================

PDM_MODULATOR -- requirements
Module: pdm_modulator

Interface
REQ-001 SHALL have parameter OSR, default 125, giving the number of PDM bits per PCM sample (2 MHz / 125 = 16 kHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of PCM sample FIFO entries (power of two).
REQ-003 SHALL have port clk, input, 1 bit: global clock, 50 MHz; one clock domain only.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port sclk, input, 1 bit: PDM bit-clock level (2 MHz), generated in the clk domain.
REQ-006 SHALL have port x_i, input, 16 bits: signed two's-complement PCM sample.
REQ-007 SHALL have port write, input, 1 bit: one-clk strobe that pushes x_i into the FIFO.
REQ-008 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-009 SHALL have port pdo, output, 1 bit: PDM output bit to the speaker or mic-loop.
REQ-010 SHALL have port underrun, output, 1 bit: one-clk pulse when a sample load finds the FIFO empty.

Function
REQ-011 SHALL register sclk into sclk_d each clk; tick = sclk & ~sclk_d, so there is exactly one tick per sclk rising edge.
REQ-012 SHALL accept a write when count < FIFO_DEPTH, or when a pop occurs in the same clk; otherwise it SHALL drop the sample silently, with FIFO contents unchanged.
REQ-013 SHALL, on a simultaneous push and pop, leave count unchanged and return the oldest entry from the pop (FIFO order).
REQ-014 SHALL drive full combinationally from count == FIFO_DEPTH.
REQ-015 SHALL hold the current sample in cur_sample and count ticks in os_cnt, which runs 0..OSR-1 and wraps to 0 on the tick at OSR-1.
REQ-016 SHALL, on a tick with os_cnt == 0, pop the FIFO head into cur_sample; if the FIFO is empty it SHALL load 0 instead and pulse underrun high for that one clk.
REQ-017 SHALL implement a second-order sigma-delta that updates only on a tick, using cur_sample as it was before any same-tick load:
- fb = +32767 when pdo = 1, -32768 when pdo = 0.
- int1_n = sat24(int1 + x - fb).
- int2_n = sat24(int2 + int1_n - fb).
- pdo <= (int2_n >= 0).
REQ-018 SHALL keep int1 and int2 as 24-bit signed values; sat24 SHALL clamp to [-8388608, +8388607] and SHALL never wrap.
REQ-019 SHALL change pdo only on the clk edge that ends a tick cycle, i.e. one clk after the first clk sampling sclk high; pdo SHALL be stable between ticks.
REQ-020 SHALL produce a new sample every OSR ticks; latency from write into an empty FIFO to the first pdo bit using that sample SHALL be at most OSR+1 ticks.

Reset
REQ-021 SHALL, while reset is high, asynchronously clear all of the following to 0:
- sclk_d, FIFO pointers and count, cur_sample, os_cnt;
- int1, int2;
- pdo, full, underrun.
REQ-022 SHALL flush the FIFO on reset asserted mid-operation; pending samples are lost and writes during reset are ignored.
REQ-023 SHALL, after reset deassertion, treat the first tick as os_cnt == 0; with the FIFO empty this gives an underrun pulse and a zero sample.

Verification
REQ-024 Bench SHALL check: reset, then no writes, 1000 ticks -> underrun pulses at ticks 1, 126, 251, ...; pdo ones count 500 +/- 2.
REQ-025 Bench SHALL check: 16 writes of 16384 paced every 125 ticks -> pdo ones density 0.75 +/- 0.01 over 1000 ticks in steady state; no underrun after the first load.
REQ-026 Bench SHALL check: 6 back-to-back writes 1..6 to an empty FIFO -> full rises after the 4th write; samples 5 and 6 are dropped; cur_sample loads 1, 2, 3, 4 and then underrun.
REQ-027 Bench SHALL check: FIFO full and write coincident with the os_cnt == 0 tick pop -> write accepted, count stays 4, order preserved.
REQ-028 Bench SHALL check: constant 32767 for 4000 ticks -> int1 and int2 stay within 24-bit range (saturation hit, no wrap); ones density >= 0.99.
REQ-029 Bench SHALL check: reset asserted mid-stream between sclk edges -> pdo, full, underrun = 0 immediately; FIFO empty on release.

Source files
------------

// File: rtl/pdm_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_modulator
//  Description : PCM-to-PDM converter. A small sample FIFO feeds a
//                second-order saturating sigma-delta loop that emits one PDM
//                bit per rising edge of the sclk level; a new PCM sample is
//                taken every OSR bit ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_modulator #(
   parameter int OSR        = 125,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sclk,
   input  logic signed [15:0] x_i,
   input  logic               write,
   output logic               full,
   output logic               pdo,
   output logic               underrun
);

   // Pointer, occupancy and oversampling-counter widths
   localparam int c_aw = $clog2(FIFO_DEPTH);
   localparam int c_cw = $clog2(FIFO_DEPTH + 1);
   localparam int c_ow = (OSR > 1) ? $clog2(OSR) : 1;

   localparam logic [c_cw-1:0] c_depth   = c_cw'(FIFO_DEPTH);
   localparam logic [c_ow-1:0] c_os_last = c_ow'(OSR - 1);

   // Loop arithmetic runs in 26 bits so the sums never wrap before clamping
   localparam logic signed [25:0] c_sat_max = 26'sd8388607;
   localparam logic signed [25:0] c_sat_min = -26'sd8388608;
   localparam logic signed [25:0] c_fb_pos  = 26'sd32767;
   localparam logic signed [25:0] c_fb_neg  = -26'sd32768;

   // Bit-clock edge detection
   logic                r_sclk_d;
   logic                w_tick;

   // Sample FIFO
   logic signed [15:0]  r_mem [FIFO_DEPTH];
   logic [c_aw-1:0]     r_wr_ptr;
   logic [c_aw-1:0]     r_rd_ptr;
   logic [c_cw-1:0]     r_count;
   logic                w_empty;
   logic                w_load;
   logic                w_pop;
   logic                w_push;

   // Sample sequencing
   logic [c_ow-1:0]     r_os_cnt;
   logic signed [15:0]  r_cur_sample;
   logic                r_underrun;

   // Sigma-delta state and next-state terms
   logic signed [23:0]  r_int1;
   logic signed [23:0]  r_int2;
   logic                r_pdo;
   logic signed [25:0]  w_fb;
   logic signed [25:0]  w_sum1;
   logic signed [25:0]  w_sum2;
   logic signed [23:0]  w_int1_n;
   logic signed [23:0]  w_int2_n;

   // Clamp a wide loop sum into the 24-bit integrator range
   function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
      if (v > c_sat_max) begin
         sat24 = 24'sh7FFFFF;
      end else if (v < c_sat_min) begin
         sat24 = 24'sh800000;
      end else begin
         sat24 = v[23:0];
      end
   endfunction

   // One tick per sclk rising edge; a load happens on the first tick of a frame
   assign w_tick  = sclk & ~r_sclk_d;
   assign w_empty = (r_count == '0);
   assign w_load  = w_tick & (r_os_cnt == '0);
   assign w_pop   = w_load & ~w_empty;
   // A full FIFO still accepts a write when the same clock frees an entry
   assign w_push  = write & ((r_count != c_depth) | w_pop);

   assign full     = (r_count == c_depth);
   assign pdo      = r_pdo;
   assign underrun = r_underrun;

   // Delayed copy of the bit clock level for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sclk_d <= 1'b0;
      end else begin
         r_sclk_d <= sclk;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keeps the count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= x_i;
      end
   end

   // Frame counter, sample load from the FIFO head, and the underrun pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_os_cnt     <= '0;
         r_cur_sample <= '0;
         r_underrun   <= 1'b0;
      end else begin
         r_underrun <= w_load & w_empty;
         if (w_tick) begin
            if (r_os_cnt == c_os_last) begin
               r_os_cnt <= '0;
            end else begin
               r_os_cnt <= r_os_cnt + c_ow'(1);
            end
         end
         if (w_load) begin
            // An empty FIFO feeds silence rather than repeating stale data
            r_cur_sample <= w_empty ? 16'sd0 : r_mem[r_rd_ptr];
         end
      end
   end

   // Next integrator values; uses the sample held before any same-tick load
   always_comb begin
      w_fb     = r_pdo ? c_fb_pos : c_fb_neg;
      w_sum1   = $signed({{2{r_int1[23]}}, r_int1})
               + $signed({{10{r_cur_sample[15]}}, r_cur_sample})
               - w_fb;
      w_int1_n = sat24(w_sum1);
      w_sum2   = $signed({{2{r_int2[23]}}, r_int2})
               + $signed({{2{w_int1_n[23]}}, w_int1_n})
               - w_fb;
      w_int2_n = sat24(w_sum2);
   end

   // Loop state and output bit advance only on a tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_int1 <= '0;
         r_int2 <= '0;
         r_pdo  <= 1'b0;
      end else if (w_tick) begin
         r_int1 <= w_int1_n;
         r_int2 <= w_int2_n;
         r_pdo  <= ~w_int2_n[23];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pdm_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdm_modulator
//  Description : Self-checking bench for pdm_modulator with a queue-based
//                behavioural model of the FIFO, frame sequencing and loop.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pdm_modulator;

   localparam int OSR   = 125;
   localparam int DEPTH = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               sclk;
   logic signed [15:0] x_i;
   logic               write;
   logic               full;
   logic               pdo;
   logic               underrun;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   int m_q[$];
   int m_cur, m_os, m_i1, m_i2;
   bit m_pdo, m_und;

   pdm_modulator #(.OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .sclk     (sclk),
      .x_i      (x_i),
      .write    (write),
      .full     (full),
      .pdo      (pdo),
      .underrun (underrun)
   );

   always #10 clk = ~clk;

   function automatic int sat24(input int v);
      if (v > 8388607) return 8388607;
      if (v < -8388608) return -8388608;
      return v;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_cur = 0; m_os = 0; m_i1 = 0; m_i2 = 0; m_pdo = 0; m_und = 0;
   endtask

   task automatic model_push(input int d);
      if (m_q.size() < DEPTH) m_q.push_back(d);
   endtask

   // One bit period: loop uses the old sample, then a frame start loads a new one
   task automatic model_tick(input bit wr, input int d);
      int fb;
      fb    = m_pdo ? 32767 : -32768;
      m_i1  = sat24(m_i1 + m_cur - fb);
      m_i2  = sat24(m_i2 + m_i1 - fb);
      m_pdo = (m_i2 >= 0);
      m_und = 0;
      if (m_os == 0) begin
         if (m_q.size() != 0) m_cur = m_q.pop_front();
         else begin m_cur = 0; m_und = 1; end
      end
      m_os = (m_os + 1) % OSR;
      if (wr) model_push(d);
   endtask

   task automatic drive_cycle(input logic s, input logic w, input logic signed [15:0] d);
      sclk = s; write = w; x_i = d;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1; sclk = 1'b0; write = 1'b0; x_i = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic write_clk(input logic signed [15:0] d);
      drive_cycle(1'b0, 1'b1, d);
      model_push(int'(d));
   endtask

   // Four-clock bit period: tick cycle then three idle cycles
   task automatic do_tick(input bit wt, input bit wg, input logic signed [15:0] d,
                          output logic p, output logic u, output int cs,
                          output int i1, output int i2, output logic f, output bit st);
      drive_cycle(1'b1, wt, d);
      model_tick(wt, int'(d));
      p  = pdo;
      u  = underrun;
      cs = int'($signed(dut.r_cur_sample));
      i1 = int'($signed(dut.r_int1));
      i2 = int'($signed(dut.r_int2));
      st = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, wg && (i == 0), d);
         if (wg && (i == 0)) model_push(int'(d));
         if (pdo !== p || underrun !== 1'b0) st = 1'b0;
      end
      f = full;
   endtask

   task automatic test_reset();
      reset = 1'b1; sclk = 1'b0; write = 1'b1; x_i = 16'sd1234;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({pdo, full, underrun} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: got pdo/full/und=%b want 000", {pdo, full, underrun});
      end
      n_tests++;
      if (dut.r_cur_sample !== '0 || dut.r_int1 !== '0 || dut.r_int2 !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got cur=%0d int1=%0d int2=%0d want 0", dut.r_cur_sample, dut.r_int1, dut.r_int2);
      end
      write = 1'b0;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_idle();
      logic p, u, f; int cs, i1, i2; bit st; int ones;
      apply_reset();
      ones = 0;
      for (int t = 1; t <= 1000; t++) begin
         do_tick(1'b0, 1'b0, 16'sd0, p, u, cs, i1, i2, f, st);
         ones += int'(p);
         n_tests++;
         if (p !== m_pdo || u !== m_und || cs != m_cur || i1 != m_i1 || i2 != m_i2 || f !== (m_q.size() == DEPTH) || !st) begin
            n_fail++;
            $display("FAIL idle_model t=%0d: got pdo=%b und=%b cur=%0d i1=%0d i2=%0d full=%b stable=%b want pdo=%b und=%b cur=%0d i1=%0d i2=%0d",
                     t, p, u, cs, i1, i2, f, st, m_pdo, m_und, m_cur, m_i1, m_i2);
         end
         n_tests++;
         if (u !== ((t - 1) % OSR == 0)) begin
            n_fail++;
            $display("FAIL idle_underrun_pos t=%0d: got %b want %b", t, u, ((t - 1) % OSR == 0));
         end
      end
      n_tests++;
      if (ones < 498 || ones > 502) begin
         n_fail++;
         $display("FAIL idle_density: got %0d ones want 500 +/- 2", ones);
      end
   endtask

   task automatic test_tone();
      logic p, u, f; int cs, i1, i2; bit st; int ones, unds;
      apply_reset();
      ones = 0; unds = 0;
      write_clk(16'sd16384);
      for (int t = 1; t <= 2000; t++) begin
         do_tick(1'b0, (t % OSR) == 50, 16'sd16384, p, u, cs, i1, i2, f, st);
         unds += int'(u);
         if (t > 1000) ones += int'(p);
         n_tests++;
         if (p !== m_pdo || u !== m_und || cs != m_cur || i1 != m_i1 || i2 != m_i2 || f !== (m_q.size() == DEPTH) || !st) begin
            n_fail++;
            $display("FAIL tone_model t=%0d: got pdo=%b und=%b cur=%0d i1=%0d i2=%0d full=%b stable=%b want pdo=%b und=%b cur=%0d i1=%0d i2=%0d",
                     t, p, u, cs, i1, i2, f, st, m_pdo, m_und, m_cur, m_i1, m_i2);
         end
      end
      n_tests++;
      if (unds != 0) begin
         n_fail++;
         $display("FAIL tone_no_underrun: got %0d pulses want 0", unds);
      end
      n_tests++;
      if (ones < 740 || ones > 760) begin
         n_fail++;
         $display("FAIL tone_density: got %0d ones per 1000 want 750 +/- 10", ones);
      end
   endtask

   task automatic test_back_to_back();
      logic p, u, f; int cs, i1, i2; bit st; int idx;
      apply_reset();
      for (int k = 1; k <= 6; k++) begin
         write_clk(16'(k));
         n_tests++;
         if (full !== (k >= DEPTH)) begin
            n_fail++;
            $display("FAIL b2b_full k=%0d: got %b want %b", k, full, (k >= DEPTH));
         end
      end
      idx = 1;
      for (int t = 1; t <= 501; t++) begin
         do_tick(1'b0, 1'b0, 16'sd0, p, u, cs, i1, i2, f, st);
         n_tests++;
         if (p !== m_pdo || u !== m_und || cs != m_cur || i1 != m_i1 || i2 != m_i2 || !st) begin
            n_fail++;
            $display("FAIL b2b_model t=%0d: got pdo=%b und=%b cur=%0d want pdo=%b und=%b cur=%0d", t, p, u, cs, m_pdo, m_und, m_cur);
         end
         if ((t - 1) % OSR == 0) begin
            n_tests++;
            if (t < 501 && (cs != idx || u !== 1'b0)) begin
               n_fail++;
               $display("FAIL b2b_load t=%0d: got cur=%0d und=%b want cur=%0d und=0", t, cs, u, idx);
            end else if (t == 501 && (cs != 0 || u !== 1'b1)) begin
               n_fail++;
               $display("FAIL b2b_underrun t=%0d: got cur=%0d und=%b want cur=0 und=1", t, cs, u);
            end
            idx++;
         end
      end
   endtask

   task automatic test_full_pop();
      logic p, u, f; int cs, i1, i2; bit st;
      logic signed [15:0] vals [5];
      apply_reset();
      for (int k = 0; k < 5; k++) vals[k] = 16'($urandom);
      for (int k = 0; k < 4; k++) write_clk(vals[k]);
      n_tests++;
      if (full !== 1'b1) begin
         n_fail++;
         $display("FAIL fullpop_pre: got full=%b want 1", full);
      end
      do_tick(1'b1, 1'b0, vals[4], p, u, cs, i1, i2, f, st);
      n_tests++;
      if (cs != int'(vals[0]) || u !== 1'b0 || f !== 1'b1) begin
         n_fail++;
         $display("FAIL fullpop_coincident: got cur=%0d und=%b full=%b want cur=%0d und=0 full=1", cs, u, f, vals[0]);
      end
      for (int t = 2; t <= 501; t++) begin
         do_tick(1'b0, 1'b0, 16'sd0, p, u, cs, i1, i2, f, st);
         n_tests++;
         if (p !== m_pdo || u !== m_und || cs != m_cur || i1 != m_i1 || i2 != m_i2 || f !== (m_q.size() == DEPTH) || !st) begin
            n_fail++;
            $display("FAIL fullpop_model t=%0d: got pdo=%b und=%b cur=%0d want pdo=%b und=%b cur=%0d", t, p, u, cs, m_pdo, m_und, m_cur);
         end
         if ((t - 1) % OSR == 0) begin
            n_tests++;
            if (cs != int'(vals[(t - 1) / OSR]) || u !== 1'b0) begin
               n_fail++;
               $display("FAIL fullpop_order t=%0d: got cur=%0d und=%b want cur=%0d und=0", t, cs, u, vals[(t - 1) / OSR]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      logic p, u, f; int cs, i1, i2; bit st; int ones;
      apply_reset();
      ones = 0;
      write_clk(16'sd32767);
      for (int t = 1; t <= 4000; t++) begin
         do_tick(1'b0, (t % OSR) == 50, 16'sd32767, p, u, cs, i1, i2, f, st);
         if (t > 3000) ones += int'(p);
         n_tests++;
         if (p !== m_pdo || u !== m_und || cs != m_cur || i1 != m_i1 || i2 != m_i2 || !st) begin
            n_fail++;
            $display("FAIL sat_model t=%0d: got pdo=%b und=%b i1=%0d i2=%0d want pdo=%b und=%b i1=%0d i2=%0d", t, p, u, i1, i2, m_pdo, m_und, m_i1, m_i2);
         end
      end
      n_tests++;
      if (ones < 990) begin
         n_fail++;
         $display("FAIL sat_density: got %0d ones per 1000 want >= 990", ones);
      end
   endtask

   task automatic test_random();
      logic p, u, f; int cs, i1, i2; bit st;
      logic signed [15:0] d;
      bit wt, wg;
      apply_reset();
      for (int t = 1; t <= 600; t++) begin
         case ($urandom_range(0, 3))
            0:       d = 16'sh7FFF;
            1:       d = 16'sh8000;
            default: d = 16'($urandom);
         endcase
         wt = ($urandom_range(0, 15) == 0);
         wg = ($urandom_range(0, 15) == 0);
         do_tick(wt, wg, d, p, u, cs, i1, i2, f, st);
         n_tests++;
         if (p !== m_pdo || u !== m_und || cs != m_cur || i1 != m_i1 || i2 != m_i2 || f !== (m_q.size() == DEPTH) || !st) begin
            n_fail++;
            $display("FAIL rand_model t=%0d: got pdo=%b und=%b cur=%0d i1=%0d i2=%0d full=%b stable=%b want pdo=%b und=%b cur=%0d i1=%0d i2=%0d full=%b",
                     t, p, u, cs, i1, i2, f, st, m_pdo, m_und, m_cur, m_i1, m_i2, (m_q.size() == DEPTH));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic p, u, f; int cs, i1, i2; bit st;
      apply_reset();
      for (int k = 0; k < 4; k++) write_clk(16'($urandom));
      for (int t = 1; t <= 10; t++) do_tick(1'b0, 1'b1, 16'($urandom), p, u, cs, i1, i2, f, st);
      n_tests++;
      if (full !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre_full: got %b want 1", full);
      end
      #3;
      reset = 1'b1;
      write = 1'b1;
      #1;
      n_tests++;
      if ({pdo, full, underrun} !== 3'b000) begin
         n_fail++;
         $display("FAIL midrst_async: got pdo/full/und=%b want 000", {pdo, full, underrun});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      write = 1'b0;
      model_reset();
      n_tests++;
      if (full !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_flush_full: got %b want 0", full);
      end
      do_tick(1'b0, 1'b0, 16'sd0, p, u, cs, i1, i2, f, st);
      n_tests++;
      if (u !== 1'b1 || cs != 0 || p !== m_pdo) begin
         n_fail++;
         $display("FAIL midrst_first_tick: got und=%b cur=%0d pdo=%b want und=1 cur=0 pdo=%b", u, cs, p, m_pdo);
      end
   endtask

   initial begin
      reset = 1'b1; sclk = 1'b0; write = 1'b0; x_i = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_idle();
      test_tone();
      test_back_to_back();
      test_full_pop();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
